range_scan: RTL and testbench

- Sequencer and reduction stage wrapped around the Collatz range block.
- Launches one range run from a base number, waits for the RAM to fill, then reads all RAM_WORDS counts back through the range block's shared start/address port.
- Reports the maximum iteration count, the starting number that produced it, and a completion flag for the board-level display/host logic.

---
 rtl/range_scan.sv | 163 ++++++++++++++++
 tb/tb_range_scan.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_scan.sv
// range_scan
//
// Sequencer and reduction stage wrapped around the Collatz range block.
// One accepted request launches a range run from `base`. The block then
// waits for the range RAM to fill and reads every count back through the
// range block's shared start/address port. It reports the largest count
// and the starting number that produced it.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req, base             start request (accepted in IDLE or DONE) and first
//                         starting number of the run
//   busy                  high from the accepted req until result_valid or
//                         timeout
//   result_valid          high in DONE until the next accepted req
//   timeout               range fill watchdog fired; sticky until next req
//   max_count, max_n      largest count read back and the number behind it
//   r_go, r_start         to the range block (go pulse; start value, then
//                         the read address)
//   r_done, r_count       from the range block (r_count has 1-cycle latency)
//   dbg_state             current sequencer state, for observation only
//
// Handshake: a req is taken only on a cycle where busy=0 (IDLE or DONE). A
// req while busy is dropped, not queued. Every taken req produces exactly one
// r_go pulse. It ends with either result_valid=1 and valid max outputs, or
// timeout=1 and max outputs left at zero.
module range_scan #(
    parameter int RAM_WORDS     = 16,
    parameter int RAM_ADDR_BITS = 4,
    parameter int TIMEOUT_BITS  = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] base,
    output logic        busy,
    output logic        result_valid,
    output logic        timeout,
    output logic [15:0] max_count,
    output logic [31:0] max_n,
    output logic        r_go,
    output logic [31:0] r_start,
    input  logic        r_done,
    input  logic [15:0] r_count,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_GUARD  = 3'd2,
        S_WAIT   = 3'd3,
        S_READ   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [TIMEOUT_BITS-1:0]  WD_ONE = TIMEOUT_BITS'(1);
    localparam logic [RAM_ADDR_BITS:0]   K_ONE  = (RAM_ADDR_BITS + 1)'(1);
    localparam logic [RAM_ADDR_BITS:0]   K_LAST = (RAM_ADDR_BITS + 1)'(RAM_WORDS);

    state_t                  state, state_nxt;
    logic [31:0]             base_q;
    logic [TIMEOUT_BITS-1:0] wdog;
    // Read cycle index: 0..RAM_WORDS-1 issue addresses, 1..RAM_WORDS capture.
    logic [RAM_ADDR_BITS:0]  rd_k;
    logic                    accept;
    logic                    wdog_fire;

    assign accept    = req && ((state == S_IDLE) || (state == S_DONE));
    // Fire on the cycle whose increment reaches all-ones, so the timeout
    // becomes visible exactly 2**TIMEOUT_BITS-1 cycles after WAIT is entered.
    assign wdog_fire = ((wdog + WD_ONE) == '1);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        result_valid = 1'b0;
        r_go         = 1'b0;
        r_start      = base_q;
        case (state)
            S_IDLE: begin
                if (req) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                busy      = 1'b1;
                r_go      = 1'b1;
                state_nxt = S_GUARD;
            end
            S_GUARD: begin
                // r_done may still show the previous run here; do not look.
                busy      = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (r_done) begin
                    state_nxt = S_READ;
                end else if (wdog_fire) begin
                    state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                // r_done is not consulted here: a drop mid-scan is ignored.
                busy    = 1'b1;
                r_start = {{(32 - RAM_ADDR_BITS){1'b0}}, rd_k[RAM_ADDR_BITS-1:0]};
                if (rd_k == K_LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                result_valid = 1'b1;
                if (req) state_nxt = S_LAUNCH;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q    <= '0;
            wdog      <= '0;
            rd_k      <= '0;
            timeout   <= 1'b0;
            max_count <= '0;
            max_n     <= '0;
        end else begin
            if (accept) begin
                base_q    <= base;
                wdog      <= '0;
                timeout   <= 1'b0;
                max_count <= '0;
                max_n     <= '0;
            end
            if (state == S_WAIT) begin
                wdog <= wdog + WD_ONE;
                rd_k <= '0;
                if (!r_done && wdog_fire) timeout <= 1'b1;
            end
            if (state == S_READ) begin
                rd_k <= rd_k + K_ONE;
                // r_count now holds the word for address rd_k-1. The first
                // word always seeds the max; later words replace it only when
                // strictly larger, so ties keep the lowest index.
                if (rd_k != '0) begin
                    if ((rd_k == K_ONE) || (r_count > max_count)) begin
                        max_count <= r_count;
                        max_n     <= base_q + 32'(rd_k - K_ONE);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_range_scan.sv
module tb_range_scan;

    localparam int RAM_WORDS     = 16;
    localparam int RAM_ADDR_BITS = 4;
    localparam int TIMEOUT_BITS  = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_READ = 3'd4;

    // ---------------- clock / reset ----------------
    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        req   = 1'b0;
    logic [31:0] base  = '0;
    logic        busy, result_valid, timeout, r_go;
    logic [15:0] max_count;
    logic [31:0] max_n, r_start;
    logic        r_done  = 1'b0;
    logic [15:0] r_count = '0;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    range_scan #(
        .RAM_WORDS    (RAM_WORDS),
        .RAM_ADDR_BITS(RAM_ADDR_BITS),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .base        (base),
        .busy        (busy),
        .result_valid(result_valid),
        .timeout     (timeout),
        .max_count   (max_count),
        .max_n       (max_n),
        .r_go        (r_go),
        .r_start     (r_start),
        .r_done      (r_done),
        .r_count     (r_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- range block model ----------------
    // ram is what the block currently exposes; pend becomes visible when the
    // fill completes, so reads taken too early return the previous run.
    logic [15:0] ram [RAM_WORDS] = '{default: 16'd0};
    logic [15:0] pend[RAM_WORDS];
    logic        running    = 1'b0;
    logic        stale_left = 1'b0;
    int          fill_left  = 0;
    int          fill_delay = 4;
    bit          stale_hold = 1'b0;
    bit          never_done = 1'b0;

    always @(posedge clk) begin
        r_count <= ram[r_start[RAM_ADDR_BITS-1:0]];
        if (r_go) begin
            running    <= !never_done;
            fill_left  <= fill_delay;
            stale_left <= stale_hold;
            if (!stale_hold) r_done <= 1'b0;
        end else begin
            if (stale_left) begin
                r_done     <= 1'b0;
                stale_left <= 1'b0;
            end
            if (running) begin
                if (fill_left == 0) begin
                    r_done  <= 1'b1;
                    running <= 1'b0;
                    for (int i = 0; i < RAM_WORDS; i++) ram[i] <= pend[i];
                end else begin
                    fill_left <= fill_left - 1;
                end
            end
        end
    end

    // ---------------- observers ----------------
    int          go_cnt   = 0;
    logic [31:0] go_start = '0;
    logic [31:0] addr_log[$];

    always @(negedge clk) begin
        if (r_go === 1'b1) begin
            go_cnt   <= go_cnt + 1;
            go_start <= r_start;
        end
        if (dbg_state === ST_READ) addr_log.push_back(r_start);
    end

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    // ---------------- driver tasks ----------------
    task automatic pulse_req(input logic [31:0] b);
        base = b;
        req  = 1'b1;
        @(negedge clk);
        req  = 1'b0;
    endtask

    // Issues a req and waits for result_valid; lat counts cycles from the
    // req cycle to the first cycle showing result_valid.
    task automatic run_and_wait(input logic [31:0] b, output int lat);
        pulse_req(b);
        lat = 1;
        while (result_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (result_valid !== 1'b1) begin
            total++; bad++;
            $display("FAIL wait_result_valid timed out after %0d cycles", lat);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        req   = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_result_valid got=%0b want=0", result_valid); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b want=0", timeout); end
        total++; if (max_count !== 16'd0) begin bad++; $display("FAIL reset_max_count got=%0h want=0", max_count); end
        total++; if (max_n !== 32'd0) begin bad++; $display("FAIL reset_max_n got=%0h want=0", max_n); end
        total++; if (r_go !== 1'b0) begin bad++; $display("FAIL reset_r_go got=%0b want=0", r_go); end
        total++; if (r_start !== 32'd0) begin bad++; $display("FAIL reset_r_start got=%0h want=0", r_start); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_IDLE); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        int g0;
        for (int i = 0; i < RAM_WORDS; i++) pend[i] = 16'd0;
        pend[0] = 16'd3; pend[1] = 16'd7; pend[2] = 16'd7; pend[3] = 16'd2;
        fill_delay = 4;
        stale_hold = 1'b0;
        g0 = go_cnt;
        addr_log.delete();
        run_and_wait(32'd27, lat);
        total++; if (go_cnt - g0 !== 1) begin bad++; $display("FAIL basic_go_pulses got=%0d want=1", go_cnt - g0); end
        total++; if (go_start !== 32'd27) begin bad++; $display("FAIL basic_go_start got=%0d want=27", go_start); end
        total++; if (addr_log.size() !== RAM_WORDS + 1) begin bad++; $display("FAIL basic_read_cycles got=%0d want=%0d", addr_log.size(), RAM_WORDS + 1); end
        for (int i = 0; i < RAM_WORDS; i++) begin
            if (i < addr_log.size()) begin
                total++;
                if (addr_log[i] !== 32'(i)) begin bad++; $display("FAIL basic_addr[%0d] got=%0d want=%0d", i, addr_log[i], i); end
            end
        end
        total++; if (max_count !== 16'd7) begin bad++; $display("FAIL basic_max_count got=%0d want=7", max_count); end
        total++; if (max_n !== 32'd28) begin bad++; $display("FAIL basic_max_n got=%0d want=28", max_n); end
        total++; if (lat !== 25) begin bad++; $display("FAIL basic_latency got=%0d want=25", lat); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%0b want=0", busy); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%0b want=0", timeout); end
    endtask

    task automatic test_all_zero();
        int lat;
        for (int i = 0; i < RAM_WORDS; i++) pend[i] = 16'd0;
        fill_delay = 4;
        run_and_wait(32'd100, lat);
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL zero_result_valid got=%0b want=1", result_valid); end
        total++; if (max_count !== 16'd0) begin bad++; $display("FAIL zero_max_count got=%0d want=0", max_count); end
        total++; if (max_n !== 32'd100) begin bad++; $display("FAIL zero_max_n got=%0d want=100", max_n); end
    endtask

    task automatic test_wrap();
        int lat;
        for (int i = 0; i < RAM_WORDS; i++) pend[i] = 16'(i);
        pend[5] = 16'hFFFF;
        fill_delay = 4;
        run_and_wait(32'hFFFF_FFFE, lat);
        total++; if (max_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_max_count got=%0h want=ffff", max_count); end
        total++; if (max_n !== 32'h0000_0003) begin bad++; $display("FAIL wrap_max_n got=%0h want=3", max_n); end
    endtask

    // The previous run left r_done high and its RAM still holds 16'hFFFF at
    // index 5; a scan started from the stale done would report that.
    task automatic test_stale_done();
        int lat;
        for (int i = 0; i < RAM_WORDS; i++) pend[i] = 16'(i + 1);
        pend[10]   = 16'd50;
        fill_delay = 4;
        stale_hold = 1'b1;
        run_and_wait(32'd1000, lat);
        stale_hold = 1'b0;
        total++; if (max_count !== 16'd50) begin bad++; $display("FAIL stale_max_count got=%0d want=50", max_count); end
        total++; if (max_n !== 32'd1010) begin bad++; $display("FAIL stale_max_n got=%0d want=1010", max_n); end
        total++; if (lat !== 25) begin bad++; $display("FAIL stale_latency got=%0d want=25", lat); end
    endtask

    task automatic test_timeout();
        int n;
        int cyc;
        int lat;
        never_done = 1'b1;
        pulse_req(32'd50);
        n = 0;
        while (dbg_state !== ST_WAIT && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++; if (dbg_state !== ST_WAIT) begin bad++; $display("FAIL timeout_reach_wait got_state=%0d want=%0d", dbg_state, ST_WAIT); end
        cyc = 0;
        while (timeout !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        total++; if (cyc !== 15) begin bad++; $display("FAIL timeout_cycles got=%0d want=15", cyc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%0b want=0", busy); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL timeout_result_valid got=%0b want=0", result_valid); end
        total++; if (max_count !== 16'd0) begin bad++; $display("FAIL timeout_max_count got=%0d want=0", max_count); end
        total++; if (max_n !== 32'd0) begin bad++; $display("FAIL timeout_max_n got=%0d want=0", max_n); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL timeout_state got=%0d want=%0d", dbg_state, ST_IDLE); end
        // A new request clears the sticky timeout and runs normally.
        never_done = 1'b0;
        fill_delay = 3;
        for (int i = 0; i < RAM_WORDS; i++) pend[i] = 16'(2 * i);
        pulse_req(32'd60);
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%0b want=0", timeout); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL timeout_rerun_busy got=%0b want=1", busy); end
        lat = 1;
        while (result_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        total++; if (lat !== 24) begin bad++; $display("FAIL rerun_latency got=%0d want=24", lat); end
        total++; if (max_count !== 16'd30) begin bad++; $display("FAIL rerun_max_count got=%0d want=30", max_count); end
        total++; if (max_n !== 32'd75) begin bad++; $display("FAIL rerun_max_n got=%0d want=75", max_n); end
    endtask

    task automatic test_busy_req_and_reset();
        int g0;
        int n;
        fill_delay = 4;
        g0 = go_cnt;
        pulse_req(32'd5);
        n = 0;
        // Hammer req while busy until the scan reaches address 9.
        while (!(dbg_state === ST_READ && r_start === 32'd9) && n < 60) begin
            req = ~req;
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        total++; if (r_start !== 32'd9) begin bad++; $display("FAIL midreset_reach_addr9 got=%0d want=9", r_start); end
        total++; if (max_count !== 16'd14) begin bad++; $display("FAIL midreset_partial_max got=%0d want=14", max_count); end
        #2 reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%0b want=0", busy); end
        total++; if (r_go !== 1'b0) begin bad++; $display("FAIL midreset_r_go got=%0b want=0", r_go); end
        total++; if (r_start !== 32'd0) begin bad++; $display("FAIL midreset_r_start got=%0h want=0", r_start); end
        total++; if (max_count !== 16'd0) begin bad++; $display("FAIL midreset_max_count got=%0h want=0", max_count); end
        total++; if (max_n !== 32'd0) begin bad++; $display("FAIL midreset_max_n got=%0h want=0", max_n); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL midreset_state got=%0d want=%0d", dbg_state, ST_IDLE); end
        @(negedge clk);
        total++; if (go_cnt - g0 !== 1) begin bad++; $display("FAIL busy_req_go_pulses got=%0d want=1", go_cnt - g0); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_all_zero();
        test_wrap();
        test_stale_done();
        test_timeout();
        test_busy_req_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
